// File: rtl/inta_sequencer.sv
// inta_sequencer: CPU-side initiator of the 8259 interrupt-acknowledge protocol.
// Issues two INTA_n pulses, captures the vector on the data bus during the second
// pulse and hands it to the core with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for synchronized intr with int_en high
// P1    | first INTA_n low pulse (PULSE_LEN clocks)
// GAP   | INTA_n high between pulses (GAP_LEN clocks)
// P2    | second INTA_n low pulse; vector sampled on its final edge
// HOLD  | vector presented, waiting for vec_ready
// RECOV | INTA_n high recovery after the handshake (GAP_LEN clocks)
module inta_sequencer #(
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       intr,
   input  logic       int_en,
   input  logic [7:0] data_in,
   output logic       inta_n,
   output logic       vec_valid,
   output logic [7:0] vec_out,
   input  logic       vec_ready,
   output logic       busy
);

   localparam int MAXLEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
   localparam int CW     = $clog2(MAXLEN) + 1;
   localparam logic [CW-1:0] PULSE_M1 = CW'(PULSE_LEN - 1);
   localparam logic [CW-1:0] GAP_M1   = CW'(GAP_LEN - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      P1    = 3'd1,
      GAP   = 3'd2,
      P2    = 3'd3,
      HOLD  = 3'd4,
      RECOV = 3'd5
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            capture;
   logic            intr_s1, intr_s;

   // two-flop synchronizer for the asynchronous PIC INT line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         intr_s1 <= 1'b0;
         intr_s  <= 1'b0;
      end else begin
         intr_s1 <= intr;
         intr_s  <= intr_s1;
      end
   end

   // next-state and shared down-counter decode
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      capture  = 1'b0;
      case (state)
         IDLE: begin
            if (intr_s && int_en) begin
               state_nx = P1;
               cnt_nx   = PULSE_M1;
            end
         end
         P1: begin
            if (cnt == '0) begin
               state_nx = GAP;
               cnt_nx   = GAP_M1;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         GAP: begin
            if (cnt == '0) begin
               state_nx = P2;
               cnt_nx   = PULSE_M1;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         P2: begin
            if (cnt == '0) begin
               state_nx = HOLD;
               capture  = 1'b1;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         HOLD: begin
            if (vec_ready) begin
               state_nx = RECOV;
               cnt_nx   = GAP_M1;
            end
         end
         RECOV: begin
            if (cnt == '0) begin
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // state register with outputs registered from the next state so they never glitch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         inta_n    <= 1'b1;
         vec_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         inta_n    <= !((state_nx == P1) || (state_nx == P2));
         vec_valid <= (state_nx == HOLD);
         busy      <= (state_nx != IDLE);
      end
   end

   // vector capture on the edge that ends the last clock of the second pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_out <= 8'h00;
      end else if (capture) begin
         vec_out <= data_in;
      end
   end

endmodule
